// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: shared opcodes, ALU selects, state encoding and helpers
// for the datapath instruction sequencer.
package datapath_ctrl_pkg;

    localparam int INSTR_W = 9;
    localparam int IDX_W   = 3;

    localparam logic [2:0] OPC_LOAD = 3'b000;
    localparam logic [2:0] OPC_MOV  = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_XOR  = 3'b011;
    localparam logic [2:0] OPC_DISP = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_t;

    // ADD and XOR are the only three-cycle instructions that go through A/G.
    function automatic logic isAluOp(input logic [2:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_XOR);
    endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// datapath_ctrl_if: instruction handshake plus datapath control strobes.
// The slave modport is the sequencer; the master modport is the instruction
// source that also observes the strobes heading to the datapath.
interface datapath_ctrl_if
    import datapath_ctrl_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 8
);
    logic                 instr_valid;
    logic [INSTR_W-1:0]   instr;
    logic [W-1:0]         instr_imm;
    logic                 instr_ready;
    logic                 done;
    logic                 err;
    logic [1:0]           op;
    logic [2*NREG-1:0]    reg_sig;
    logic                 data_in;
    logic [W-1:0]         data;
    logic                 A_in;
    logic                 G_in;
    logic                 G_out;

    modport master (
        output instr_valid, instr, instr_imm,
        input  instr_ready, done, err, op, reg_sig, data_in, data, A_in, G_in, G_out
    );

    modport slave (
        input  instr_valid, instr, instr_imm,
        output instr_ready, done, err, op, reg_sig, data_in, data, A_in, G_in, G_out
    );
endinterface

// File: rtl/datapath_ctrl_regsel.sv
// datapath_ctrl_regsel: turns one in-select and one out-select into the
// interleaved per-register strobe vector (Rk_in at 2N-1-2k, Rk_out at 2N-2-2k).
module datapath_ctrl_regsel
    import datapath_ctrl_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic [IDX_W-1:0]  in_idx_i,
    input  logic              in_en_i,
    input  logic [IDX_W-1:0]  out_idx_i,
    input  logic              out_en_i,
    output logic [2*NREG-1:0] reg_sig_o
);

    // Decode both selects into their strobe positions; at most one bit of each kind.
    always_comb begin
        reg_sig_o = '0;
        for (int k = 0; k < NREG; k++) begin
            reg_sig_o[2*NREG-1-2*k] = in_en_i  && (in_idx_i  == IDX_W'(k));
            reg_sig_o[2*NREG-2-2*k] = out_en_i && (out_idx_i == IDX_W'(k));
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore sequencer that turns one decoded instruction at a time
// into registered datapath strobes (LOAD/MOV/DISP one cycle, ADD/XOR three).
// Optional build macro DATAPATH_CTRL_B2B_EN: ready is also raised in the done
// cycle so a waiting instruction starts with no idle bubble.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic           clk,
    input  logic           reset,
    datapath_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic [2:0]         opc_q, opc_d;
    logic [IDX_W-1:0]   rx_q, rx_d;
    logic [IDX_W-1:0]   ry_q, ry_d;
    logic [W-1:0]       data_q, data_d;
    logic [1:0]         op_q, op_d;
    logic [2*NREG-1:0]  regSig_q, regSig_d;
    logic               dataIn_q, dataIn_d;
    logic               aIn_q, aIn_d;
    logic               gIn_q, gIn_d;
    logic               gOut_q, gOut_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   inIdx, outIdx;
    logic               inEn, outEn;
    logic               instrReady;
    logic               accept;

`ifdef DATAPATH_CTRL_B2B_EN
    assign instrReady = (state_q == ST_IDLE) || done_q;
`else
    assign instrReady = (state_q == ST_IDLE);
`endif

    assign accept = bus.instr_valid && instrReady;

    // Next state and instruction latch; acceptance always restarts at T1.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_T1:   state_d = isAluOp(opc_q) ? ST_T2 : ST_IDLE;
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = ST_T1;
            opc_d   = bus.instr[8:6];
            rx_d    = bus.instr[5:3];
            ry_d    = bus.instr[2:0];
        end
    end

    // Strobes for the cycle being entered, so every output comes straight from a flop.
    always_comb begin
        inIdx    = '0;
        inEn     = 1'b0;
        outIdx   = '0;
        outEn    = 1'b0;
        dataIn_d = 1'b0;
        aIn_d    = 1'b0;
        gIn_d    = 1'b0;
        gOut_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        op_d     = op_q;
        data_d   = data_q;
        case (state_d)
            ST_T1: begin
                case (opc_d)
                    OPC_LOAD: begin
                        inIdx    = rx_d;
                        inEn     = 1'b1;
                        dataIn_d = 1'b1;
                        data_d   = bus.instr_imm;
                        done_d   = 1'b1;
                    end
                    OPC_MOV: begin
                        inIdx  = rx_d;
                        inEn   = 1'b1;
                        outIdx = ry_d;
                        outEn  = 1'b1;
                        done_d = 1'b1;
                    end
                    OPC_ADD, OPC_XOR: begin
                        outIdx = rx_d;
                        outEn  = 1'b1;
                        aIn_d  = 1'b1;
                    end
                    OPC_DISP: begin
                        outIdx = rx_d;
                        outEn  = 1'b1;
                        done_d = 1'b1;
                    end
                    default: begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                endcase
            end
            ST_T2: begin
                outIdx = ry_d;
                outEn  = 1'b1;
                gIn_d  = 1'b1;
                op_d   = (opc_d == OPC_XOR) ? ALU_XOR : ALU_ADD;
            end
            ST_T3: begin
                gOut_d = 1'b1;
                inIdx  = rx_d;
                inEn   = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    datapath_ctrl_regsel #(.NREG(NREG)) u_regsel (
        .in_idx_i  (inIdx),
        .in_en_i   (inEn),
        .out_idx_i (outIdx),
        .out_en_i  (outEn),
        .reg_sig_o (regSig_d)
    );

    // State, latched instruction and registered outputs; reset aborts immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opc_q    <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            data_q   <= '0;
            op_q     <= ALU_ADD;
            regSig_q <= '0;
            dataIn_q <= 1'b0;
            aIn_q    <= 1'b0;
            gIn_q    <= 1'b0;
            gOut_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            data_q   <= data_d;
            op_q     <= op_d;
            regSig_q <= regSig_d;
            dataIn_q <= dataIn_d;
            aIn_q    <= aIn_d;
            gIn_q    <= gIn_d;
            gOut_q   <= gOut_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.instr_ready = instrReady;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.op          = op_q;
    assign bus.reg_sig     = regSig_q;
    assign bus.data_in     = dataIn_q;
    assign bus.data        = data_q;
    assign bus.A_in        = aIn_q;
    assign bus.G_in        = gIn_q;
    assign bus.G_out       = gOut_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed bench for datapath_ctrl with a small behavioural
// model of the 8-register datapath hanging off the control strobes.
// Expectations follow DATAPATH_CTRL_B2B_EN when it is defined.
module tb_datapath_ctrl;

    localparam int W  = 16;
    localparam int NR = 8;

`ifdef DATAPATH_CTRL_B2B_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic invOn;

    logic [W-1:0] regs [NR];
    logic [W-1:0] regA;
    logic [W-1:0] regG;
    logic [W-1:0] busVal;

    datapath_ctrl_if #(.W(W), .NREG(NR)) bus ();

    datapath_ctrl #(.W(W), .NREG(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath bus: the immediate, G, or whichever register is driving out.
    always_comb begin
        busVal = '0;
        if (bus.data_in)
            busVal = bus.data;
        else if (bus.G_out)
            busVal = regG;
        else
            for (int k = 0; k < NR; k++)
                if (bus.reg_sig[2*NR-2-2*k]) busVal = regs[k];
    end

    // Datapath registers capture the bus on their in-strobes.
    always @(posedge clk) begin
        for (int k = 0; k < NR; k++)
            if (bus.reg_sig[2*NR-1-2*k]) regs[k] <= busVal;
        if (bus.A_in) regA <= busVal;
        if (bus.G_in) regG <= (bus.op == 2'b01) ? (regA ^ busVal) : (regA + busVal);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE, let it be accepted, then withdraw valid.
    task automatic applyStimulus(input logic [2:0] opc, input logic [2:0] rx,
                                 input logic [2:0] ry, input logic [W-1:0] imm);
        bus.instr_valid = 1'b1;
        bus.instr       = {opc, rx, ry};
        bus.instr_imm   = imm;
        stepClk();
        bus.instr_valid = 1'b0;
        bus.instr       = 9'h1FF;
        bus.instr_imm   = 16'hDEAD;
    endtask

    // Bus-driver and register-load exclusivity, every cycle outside reset.
    always @(negedge clk) begin
        int drivers;
        int loads;
        if (invOn && !reset) begin
            drivers = 32'(bus.G_out) + 32'(bus.data_in);
            loads   = 0;
            for (int k = 0; k < NR; k++) begin
                drivers += 32'(bus.reg_sig[2*NR-2-2*k]);
                loads   += 32'(bus.reg_sig[2*NR-1-2*k]);
            end
            checkOutput("single_bus_driver", 32'(drivers <= 1), 32'd1);
            checkOutput("single_reg_in", 32'(loads <= 1), 32'd1);
        end
    end

    initial begin
        int n;
        int doneCnt;
        int issued;
        logic acc;
        logic [2:0]   b2bRx  [3] = '{3'd4, 3'd5, 3'd6};
        logic [W-1:0] b2bImm [3] = '{16'h0AAA, 16'h0BBB, 16'h0CCC};

        checks   = 0;
        failures = 0;
        invOn    = 1'b0;
        for (int k = 0; k < NR; k++) regs[k] = '0;
        regA = '0;
        regG = '0;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.instr_imm   = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_reg_sig", 32'(bus.reg_sig), 32'h0);
        checkOutput("rst_data", 32'(bus.data), 32'h0);
        checkOutput("rst_op", 32'(bus.op), 32'h0);
        checkOutput("rst_strobes", 32'({bus.data_in, bus.A_in, bus.G_in, bus.G_out, bus.done, bus.err}), 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(bus.instr_ready), 32'h1);
        stepClk();
        invOn = 1'b1;

        // LOAD R0,0x0001
        applyStimulus(3'b000, 3'd0, 3'd0, 16'h0001);
        checkOutput("load0_reg_sig", 32'(bus.reg_sig), 32'h8000);
        checkOutput("load0_data_in", 32'(bus.data_in), 32'h1);
        checkOutput("load0_data", 32'(bus.data), 32'h0001);
        checkOutput("load0_done", 32'(bus.done), 32'h1);
        checkOutput("load0_ready_t1", 32'(bus.instr_ready), 32'(B2B));
        stepClk();
        checkOutput("load0_done_pulse", 32'(bus.done), 32'h0);
        checkOutput("load0_idle_strobes", 32'({bus.reg_sig, bus.data_in}), 32'h0);
        checkOutput("load0_data_hold", 32'(bus.data), 32'h0001);
        checkOutput("load0_ready_idle", 32'(bus.instr_ready), 32'h1);
        checkOutput("model_r0_load", 32'(regs[0]), 32'h0001);

        // LOAD R1,0x0002
        applyStimulus(3'b000, 3'd1, 3'd0, 16'h0002);
        checkOutput("load1_reg_sig", 32'(bus.reg_sig), 32'h2000);
        checkOutput("load1_data", 32'(bus.data), 32'h0002);
        checkOutput("load1_done", 32'(bus.done), 32'h1);
        stepClk();
        checkOutput("model_r1_load", 32'(regs[1]), 32'h0002);

        // ADD R0,R1
        applyStimulus(3'b010, 3'd0, 3'd1, 16'h0000);
        checkOutput("add_t1_reg_sig", 32'(bus.reg_sig), 32'h4000);
        checkOutput("add_t1_a_in", 32'(bus.A_in), 32'h1);
        checkOutput("add_t1_done", 32'(bus.done), 32'h0);
        stepClk();
        checkOutput("add_t2_reg_sig", 32'(bus.reg_sig), 32'h1000);
        checkOutput("add_t2_g_in", 32'(bus.G_in), 32'h1);
        checkOutput("add_t2_op", 32'(bus.op), 32'h0);
        stepClk();
        checkOutput("add_t3_reg_sig", 32'(bus.reg_sig), 32'h8000);
        checkOutput("add_t3_g_out", 32'(bus.G_out), 32'h1);
        checkOutput("add_t3_done", 32'(bus.done), 32'h1);
        stepClk();
        checkOutput("model_r0_add", 32'(regs[0]), 32'h0003);

        // MOV R1,R0
        applyStimulus(3'b001, 3'd1, 3'd0, 16'h0000);
        checkOutput("mov_reg_sig", 32'(bus.reg_sig), 32'h6000);
        checkOutput("mov_done", 32'(bus.done), 32'h1);
        stepClk();
        checkOutput("model_r1_mov", 32'(regs[1]), 32'h0003);

        // XOR R0,R1
        applyStimulus(3'b011, 3'd0, 3'd1, 16'h0000);
        checkOutput("xor_t1_reg_sig", 32'(bus.reg_sig), 32'h4000);
        stepClk();
        checkOutput("xor_t2_op", 32'(bus.op), 32'h1);
        checkOutput("xor_t2_g_in", 32'(bus.G_in), 32'h1);
        stepClk();
        checkOutput("xor_t3_done", 32'(bus.done), 32'h1);
        stepClk();
        checkOutput("model_r0_xor", 32'(regs[0]), 32'h0000);
        checkOutput("xor_op_hold", 32'(bus.op), 32'h1);

        // DISP R0
        applyStimulus(3'b100, 3'd0, 3'd0, 16'h0000);
        checkOutput("disp_reg_sig", 32'(bus.reg_sig), 32'h4000);
        checkOutput("disp_bus", 32'(busVal), 32'h0000);
        checkOutput("disp_done", 32'(bus.done), 32'h1);
        stepClk();

        // Illegal opcode 111
        applyStimulus(3'b111, 3'd2, 3'd3, 16'h0000);
        checkOutput("ill_err_done", 32'({bus.err, bus.done}), 32'h3);
        checkOutput("ill_strobes", 32'({bus.reg_sig, bus.data_in, bus.A_in, bus.G_in, bus.G_out}), 32'h0);
        checkOutput("ill_ready_t1", 32'(bus.instr_ready), 32'(B2B));
        stepClk();
        checkOutput("ill_ready_back", 32'(bus.instr_ready), 32'h1);
        checkOutput("ill_err_pulse", 32'(bus.err), 32'h0);

        // ADD R2,R3 aborted by reset in T2
        applyStimulus(3'b010, 3'd2, 3'd3, 16'h0000);
        stepClk();
        checkOutput("abort_t2_reg_sig", 32'(bus.reg_sig), 32'h0100);
        reset = 1'b1;
        #1;
        checkOutput("abort_strobes", 32'({bus.reg_sig, bus.A_in, bus.G_in, bus.G_out, bus.done}), 32'h0);
        stepClk();
        checkOutput("abort_no_done", 32'(bus.done), 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(bus.instr_ready), 32'h1);
        stepClk();
        checkOutput("abort_idle", 32'({bus.done, bus.reg_sig, bus.G_out}), 32'h0);

        // Three LOADs with valid held high
        bus.instr_valid = 1'b1;
        bus.instr       = {3'b000, b2bRx[0], 3'd0};
        bus.instr_imm   = b2bImm[0];
        issued  = 1;
        n       = 0;
        doneCnt = 0;
        while (doneCnt < 3 && n < 20) begin
            acc = bus.instr_valid && bus.instr_ready;
            stepClk();
            n++;
            if (bus.done) doneCnt++;
            if (acc) begin
                if (issued < 3) begin
                    bus.instr     = {3'b000, b2bRx[issued], 3'd0};
                    bus.instr_imm = b2bImm[issued];
                    issued++;
                end else begin
                    bus.instr_valid = 1'b0;
                end
            end
        end
        bus.instr_valid = 1'b0;
        checkOutput("b2b_done_count", 32'(doneCnt), 32'd3);
        checkOutput("b2b_cycles", 32'(n), B2B ? 32'd3 : 32'd5);
        stepClk();
        checkOutput("b2b_r4", 32'(regs[4]), 32'h0AAA);
        checkOutput("b2b_r5", 32'(regs[5]), 32'h0BBB);
        checkOutput("b2b_r6", 32'(regs[6]), 32'h0CCC);
        stepClk();

        invOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Instruction sequencer for the 8-register, 16-bit bus datapath. Accepts one decoded instruction at a time over a valid/ready handshake and drives the datapath's register in/out strobes, immediate-load, A/G register strobes and ALU op select, cycle by cycle, so that LOAD, MOV, ADD, XOR and DISP execute without hand-written strobe sequences. Sits directly in front of `datapath`; its outputs connect 1:1 to the datapath control inputs.

## Interface
- `W`, 16, bus/data width
- `NREG`, 8, number of general registers (reg_sig width = 2*NREG)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high; clears all state and outputs
- `instr_valid` in 1: instruction present
- `instr` in 9: [8:6] opcode, [5:3] rx, [2:0] ry
- `instr_imm` in W: immediate for LOAD, sampled at acceptance
- `instr_ready` out 1: controller can accept
- `done` out 1: one-cycle pulse in last control cycle of an instruction
- `err` out 1: one-cycle pulse for illegal opcode
- `op` out 2: ALU select, 00 ADD, 01 XOR
- `reg_sig` out 2*NREG: register Rk in-strobe at bit 2*NREG-1-2k, out-strobe at bit 2*NREG-2-2k
- `data_in` out 1: drive `data` onto bus
- `data` out W: immediate value
- `A_in`, `G_in`, `G_out` out 1 each: A load, G load, G onto bus

## Operation
- Opcodes: 000 LOAD rx,imm; 001 MOV rx,ry (rx←ry); 010 ADD rx,ry; 011 XOR rx,ry; 100 DISP rx; 101–111 illegal.
- States: IDLE, T1, T2, T3. Acceptance when `instr_valid && instr_ready`; opcode/rx/ry/imm latched.
- LOAD: T1 = `data`=imm, `data_in`, Rx_in, `done` → IDLE.
- MOV: T1 = Ry_out, Rx_in, `done` → IDLE.
- DISP: T1 = Rx_out, `done` → IDLE.
- ADD/XOR: T1 = Rx_out, `A_in`; T2 = Ry_out, `G_in`, `op`; T3 = `G_out`, Rx_in, `done` → IDLE.
- Illegal: T1 = no strobes, `err` and `done` → IDLE.
- rx == ry legal for all opcodes (ADD R0,R0 doubles R0).
- Invariant: at most one bus driver per cycle among {any Rk_out, `G_out`, `data_in`}; at most one Rk_in.
- `op` and `data` hold last driven value between instructions; all strobes 0 outside their cycle.

## Timing
- All outputs registered (Moore). Instruction accepted at edge k → T1 strobes valid from edge k to k+1, sampled by datapath at edge k+1.
- Latency accept→done: 1 cycle (LOAD/MOV/DISP/illegal), 3 cycles (ADD/XOR).
- `instr_ready` = 1 only in IDLE (base build); `instr_valid` may stay high, next accept occurs in IDLE.
- Reset values: state IDLE, `instr_ready` 1 after reset release, `reg_sig` 0, `data` 0, `op` 00, `data_in`/`A_in`/`G_in`/`G_out`/`done`/`err` 0.
- Reset mid-instruction: strobes drop asynchronously, instruction aborted, no `done`.
- `instr` changes while not accepted are ignored.

## Configuration
- `DATAPATH_CTRL_B2B_EN` defined: `instr_ready` also asserted in the `done` cycle; accepted instruction enters T1 on the next edge with zero bubble. Undefined: ready only in IDLE, one idle cycle between instructions.

## Structure
- Package `datapath_ctrl_pkg`: opcode constants, state encoding, ALU op constants (ADD=00, XOR=01).
- Sub-module `datapath_ctrl_regsel`: combinational encoder (in_idx, in_en, out_idx, out_en) → reg_sig; reused for both strobes.

## Test plan
- LOAD R0,0x0001 then LOAD R1,0x0002 → T1 each: `reg_sig`=0x8000/0x2000, `data_in`=1, `data` matches; `done` 1 cycle each.
- ADD R0,R1 → T1 `reg_sig`=0x4000+`A_in`; T2 0x1000+`G_in`, `op`=00; T3 `G_out`+0x8000, `done`; datapath R0=0x0003.
- XOR R0,R1 after MOV R1,R0 (0x6000 in T1) → `op`=01 in T2, R0=0x0000; DISP R0 shows 0x4000, `bus_output`=0x0000.
- Opcode 111 → `err`+`done` in T1, `reg_sig`=0, no strobes; ready returns next cycle.
- `reset` asserted during ADD T2 → all strobes 0 immediately, no `done`, IDLE with ready after release.
- Back-to-back valid stream with and without `DATAPATH_CTRL_B2B_EN` → 3 LOADs finish in 3 vs 5 cycles; bus-driver invariant checked every cycle.
